// File: rtl/spu_sram_read.sv
// spu_sram_read: issues a burst of sequential SRAM reads and re-times the returned
// words into a valid-qualified stream, advancing only on cke cycles.
module spu_sram_read #(
   parameter int  ADDR_BITS    = 10,
   parameter int  DATA_BITS    = 8,
   parameter int  READ_LATENCY = 1,
   parameter type m_data_t     = logic signed [DATA_BITS-1:0]
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cke,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] start_addr,
   input  logic [ADDR_BITS:0]   length,
   output logic                 busy,
   output logic                 done,
   output logic                 sram_en,
   output logic [ADDR_BITS-1:0] sram_addr,
   input  logic [DATA_BITS-1:0] sram_rdata,
   output m_data_t              m_data,
   output logic                 m_valid
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   localparam logic [ADDR_BITS:0] ONE = 1;
   state_t                  state;
   logic [ADDR_BITS:0]      remain;
   logic [1:0]              cnt;
   logic [READ_LATENCY-1:0] vp;
   assign sram_en = cke & (state == RUN) & reset;
   // vp mirrors the SRAM read pipeline so its tail lines up with sram_rdata
   always_ff @(posedge clk)
      if (!reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         sram_addr <= '0;
         remain    <= '0;
         cnt       <= '0;
         vp        <= '0;
      end else if (cke) begin
         done    <= 1'b0;
         vp      <= READ_LATENCY'({vp, sram_en});
         m_valid <= vp[READ_LATENCY-1];
         if (vp[READ_LATENCY-1]) m_data <= m_data_t'($signed(sram_rdata));
         case (state)
            IDLE: if (start) begin
               if (length == '0) done <= 1'b1;
               else begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  sram_addr <= start_addr;
                  remain    <= length;
               end
            end
            RUN: begin
               sram_addr <= sram_addr + ADDR_BITS'(1);
               remain    <= remain - ONE;
               if (remain == ONE) begin
                  state <= DRAIN;
                  cnt   <= '0;
               end
            end
            DRAIN: begin
               cnt <= cnt + 2'd1;
               if (cnt == 2'(READ_LATENCY - 1)) done <= 1'b1;
               if (cnt == 2'(READ_LATENCY)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_spu_sram_read.sv
// tb_spu_sram_read: three DUTs (READ_LATENCY 1..3) share stimulus; each is checked
// cycle by cycle against expectations derived from the transfer's cke-cycle count.
module tb_spu_sram_read;
   logic       clk = 0, reset = 0, cke = 0, start = 0;
   logic [3:0] start_addr = 0;
   logic [4:0] length = 0;
   logic [2:0] busy, done, en, mv;
   logic [3:0] addr [3];
   logic [7:0] rdata [3];
   logic [7:0] mdata [3];
   logic [7:0] mem [16];
   int checks, errors;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int RL = g + 1;
      localparam int W = RL * 8;
      logic [W-1:0] sh = '0;
      always @(posedge clk) if (cke) sh <= W'({sh, en[g] ? mem[addr[g]] : sh[7:0]});
      assign rdata[g] = sh[W-1 -: 8];
      spu_sram_read #(.ADDR_BITS(4), .DATA_BITS(8), .READ_LATENCY(RL)) dut (
         .clk(clk), .reset(reset), .cke(cke), .start(start), .start_addr(start_addr),
         .length(length), .busy(busy[g]), .done(done[g]), .sram_en(en[g]),
         .sram_addr(addr[g]), .sram_rdata(rdata[g]), .m_data(mdata[g]), .m_valid(mv[g]));
   end

   task automatic run_xfer(input logic [3:0] sa, input int len, input bit rnd, input bit ign, input logic [31:0] low);
      int e, it, r;
      bit eb, ed, ee, ev, cmd;
      logic [7:0] emd;
      e = 0;
      it = 0;
      while (e < len + 5 && it < 500) begin
         @(posedge clk); #1;
         cke = (it == 0) || (!(it < 32 && low[it]) && (!rnd || $urandom_range(0, 3) != 0));
         start = (it == 0) || (ign && e >= 1 && e <= len && $urandom_range(0, 1) == 1);
         start_addr = (it == 0) ? sa : 4'($urandom);
         length = (it == 0) ? 5'(len) : 5'($urandom_range(0, 16));
         #1;
         for (int g = 0; g < 3; g++) begin
            r = g + 1;
            if (it == 0) begin
               checks++;
               if (busy[g] !== 1'b0 || done[g] !== 1'b0) begin
                  errors++;
                  $display("FAIL idle_at_start rl=%0d busy=%b done=%b exp 0 0", r, busy[g], done[g]);
               end
               continue;
            end
            eb = len != 0 && e >= 1 && e <= len + 1 + r;
            ed = (len == 0) ? e == 1 : e == len + 1 + r;
            ee = cke && len != 0 && e >= 1 && e <= len;
            ev = len != 0 && e >= 2 + r && e <= len + 1 + r;
            cmd = ev || (len != 0 && e > len + 1 + r);
            emd = mem[4'(int'(sa) + (ev ? e - 2 - r : len - 1))];
            checks++;
            if (busy[g] !== eb) begin
               errors++;
               $display("FAIL busy rl=%0d cyc=%0d got %b exp %b", r, e, busy[g], eb);
            end
            checks++;
            if (done[g] !== ed) begin
               errors++;
               $display("FAIL done rl=%0d cyc=%0d got %b exp %b", r, e, done[g], ed);
            end
            checks++;
            if (en[g] !== ee) begin
               errors++;
               $display("FAIL sram_en rl=%0d cyc=%0d cke=%b got %b exp %b", r, e, cke, en[g], ee);
            end
            checks++;
            if (mv[g] !== ev) begin
               errors++;
               $display("FAIL m_valid rl=%0d cyc=%0d got %b exp %b", r, e, mv[g], ev);
            end
            if (ee) begin
               checks++;
               if (addr[g] !== 4'(int'(sa) + e - 1)) begin
                  errors++;
                  $display("FAIL sram_addr rl=%0d cyc=%0d got %0d exp %0d", r, e, addr[g], 4'(int'(sa) + e - 1));
               end
            end
            if (cmd) begin
               checks++;
               if (mdata[g] !== emd) begin
                  errors++;
                  $display("FAIL m_data rl=%0d cyc=%0d got %h exp %h", r, e, mdata[g], emd);
               end
            end
         end
         if (cke) e++;
         it++;
      end
      start = 0;
      checks++;
      if (it >= 500) begin
         errors++;
         $display("FAIL timeout got %0d cke cycles exp %0d", e, len + 5);
      end
   endtask

   task automatic test_reset;
      reset = 0;
      cke = 1;
      repeat (2) @(posedge clk);
      #1 cke = 0;
      @(posedge clk); #2;
      for (int g = 0; g < 3; g++) begin
         checks++;
         if ({busy[g], done[g], mv[g], en[g]} !== 4'b0 || addr[g] !== 4'd0 || mdata[g] !== 8'd0) begin
            errors++;
            $display("FAIL reset rl=%0d got b%b d%b v%b e%b a%0d m%h exp all 0", g + 1, busy[g], done[g], mv[g], en[g], addr[g], mdata[g]);
         end
      end
      reset = 1;
      cke = 1;
   endtask

   task automatic test_basic;
      run_xfer(4'd5, 4, 0, 0, 0);
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      cke = 1;
      start = 1;
      start_addr = 4'd3;
      length = 5'd8;
      @(posedge clk); #1;
      start = 0;
      @(posedge clk); #1;
      reset = 0;
      #1;
      checks++;
      if (en !== 3'b0) begin
         errors++;
         $display("FAIL reset_mid_en got %b exp 000", en);
      end
      @(posedge clk); #2;
      for (int g = 0; g < 3; g++) begin
         checks++;
         if ({busy[g], done[g], mv[g], en[g]} !== 4'b0 || mdata[g] !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid rl=%0d got b%b d%b v%b e%b m%h exp all 0", g + 1, busy[g], done[g], mv[g], en[g], mdata[g]);
         end
      end
      reset = 1;
      run_xfer(4'd9, 2, 0, 0, 0);
   endtask

   task automatic test_wrap;
      run_xfer(4'd14, 4, 0, 0, 0);
      run_xfer(4'($urandom), 16, 0, 0, 0);
   endtask

   task automatic test_stall;
      run_xfer(4'd6, 3, 0, 0, 32'b100_1100);
   endtask

   task automatic test_zero_ignore;
      run_xfer(4'd7, 0, 0, 0, 0);
      run_xfer(4'd2, 6, 0, 1, 0);
   endtask

   task automatic test_sweep;
      repeat (8) run_xfer(4'($urandom), $urandom_range(1, 16), 1, 1, 0);
      run_xfer(4'($urandom), 16, 1, 1, 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int a = 0; a < 16; a++) mem[a] = 8'(a);
      test_reset;
      test_basic;
      test_reset_mid;
      for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
      test_wrap;
      test_stall;
      test_zero_ignore;
      test_sweep;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
